// File: rtl/gshare_branch_predictor_pkg.sv
// gshare_branch_predictor_pkg
//   Shared constants and types for the gshare branch predictor slice.
//   - GSH_* localparams: default geometry of the predictor.
//   - TWO_BIT_SAT_COUNTER: names of the width-2 counter encoding.
//   - gsh_btb_entry_t: BTB entry layout at the default BTB depth.
//   - gsh_pc_plus4: sequential fetch address, wraps at 32 bits.
package gshare_branch_predictor_pkg;

  localparam int GSH_PHT_DEPTH = 64;
  localparam int GSH_BTB_DEPTH = 128;
  localparam int GSH_GHR_WIDTH = 6;
  localparam int GSH_CTR_WIDTH = 2;

  localparam int GSH_BTB_TAG_W = 32 - $clog2(GSH_BTB_DEPTH) - 2;

  // Encoding of a 2-bit counter; the MSB is the predicted direction.
  typedef enum logic [1:0] {
    STRONG_NOT    = 2'd0,
    WEAKLY_NOT    = 2'd1,
    WEAKLY_TAKEN  = 2'd2,
    STRONG_TAKEN  = 2'd3
  } TWO_BIT_SAT_COUNTER;

  typedef struct packed {
    logic                     valid;
    logic [GSH_BTB_TAG_W-1:0] tag;
    logic [31:0]              target;
    logic                     uncond;
  } gsh_btb_entry_t;

  function automatic logic [31:0] gsh_pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/gshare_branch_predictor_pht.sv
// gsh_pht
//   Pattern history table: array of saturating counters with one
//   combinational read port and one registered update port.
//   Ports:
//     clk, rst_n   clock, async active-low reset (counters -> weakly not-taken)
//     i_rd_idx     lookup index
//     o_rd_ctr     counter value at i_rd_idx (pre-update on same-cycle write)
//     i_upd_en     apply an update this cycle
//     i_upd_idx    update index
//     i_upd_inc    1 = saturating increment, 0 = saturating decrement
module gsh_pht #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
  output logic [WIDTH-1:0]         o_rd_ctr,
  input  logic                     i_upd_en,
  input  logic [$clog2(DEPTH)-1:0] i_upd_idx,
  input  logic                     i_upd_inc
);

  localparam logic [WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [WIDTH-1:0] CTR_ONE  = WIDTH'(1);
  // Largest value whose MSB is clear: weakest not-taken state.
  localparam logic [WIDTH-1:0] CTR_INIT = WIDTH'((1 << (WIDTH - 1)) - 1);

  logic [WIDTH-1:0] r_ctr [DEPTH];
  logic [WIDTH-1:0] w_upd_cur;

  assign o_rd_ctr  = r_ctr[i_rd_idx];
  assign w_upd_cur = r_ctr[i_upd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_ctr[i] <= CTR_INIT;
    end else if (i_upd_en) begin
      if (i_upd_inc) begin
        if (w_upd_cur != CTR_MAX) r_ctr[i_upd_idx] <= w_upd_cur + CTR_ONE;
      end else begin
        if (w_upd_cur != '0) r_ctr[i_upd_idx] <= w_upd_cur - CTR_ONE;
      end
    end
  end

endmodule

// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor
//   Fetch-stage direction/target predictor: PHT of saturating counters
//   (gshare or bimodal indexing) plus a tagged BTB. Lookup is combinational
//   from registered state; training comes from the ROB head at commit.
//   Ports:
//     clk, rst_n     clock, async active-low reset
//     i_pred_req     fetch lookup valid (advances speculative history)
//     i_pred_pc      fetch PC
//     o_pred_hit     BTB hit for i_pred_pc
//     o_pred_taken   predicted taken
//     o_pred_target  next fetch PC
//     o_pred_ghr     speculative history used for this lookup
//     i_upd_valid    committing control instruction
//     i_upd_pc       its PC
//     i_upd_is_br    1 = conditional branch, 0 = jal/jalr
//     i_upd_taken    resolved direction
//     i_upd_target   resolved target
//     i_upd_miss     mispredicted (flush this cycle)
module gshare_branch_predictor
  import gshare_branch_predictor_pkg::*;
#(
  parameter int PHT_DEPTH  = GSH_PHT_DEPTH,
  parameter int BTB_DEPTH  = GSH_BTB_DEPTH,
  parameter int GHR_WIDTH  = GSH_GHR_WIDTH,
  parameter int CTR_WIDTH  = GSH_CTR_WIDTH,
  parameter int USE_GSHARE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_pred_req,
  input  logic [31:0]          i_pred_pc,
  output logic                 o_pred_hit,
  output logic                 o_pred_taken,
  output logic [31:0]          o_pred_target,
  output logic [GHR_WIDTH-1:0] o_pred_ghr,
  input  logic                 i_upd_valid,
  input  logic [31:0]          i_upd_pc,
  input  logic                 i_upd_is_br,
  input  logic                 i_upd_taken,
  input  logic [31:0]          i_upd_target,
  input  logic                 i_upd_miss
);

  localparam int PHT_IDX_W = $clog2(PHT_DEPTH);
  localparam int BTB_IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W     = 32 - BTB_IDX_W - 2;

  logic [BTB_DEPTH-1:0] r_btb_valid;
  logic [TAG_W-1:0]     r_btb_tag    [BTB_DEPTH];
  logic [31:0]          r_btb_target [BTB_DEPTH];
  logic                 r_btb_uncond [BTB_DEPTH];
  logic [GHR_WIDTH-1:0] r_spec_ghr;
  logic [GHR_WIDTH-1:0] r_commit_ghr;

  logic [BTB_IDX_W-1:0] w_lkp_btb_idx;
  logic [TAG_W-1:0]     w_lkp_tag;
  logic                 w_lkp_uncond;
  logic [PHT_IDX_W-1:0] w_lkp_pht_idx;
  logic [CTR_WIDTH-1:0] w_lkp_ctr;
  logic                 w_hit;
  logic                 w_taken;
  logic [BTB_IDX_W-1:0] w_upd_btb_idx;
  logic [PHT_IDX_W-1:0] w_upd_pht_idx;
  logic                 w_upd_br;
  logic [GHR_WIDTH-1:0] w_commit_ghr_next;
  logic                 w_unused_pc_bits;

  // Byte offset within a 4-byte instruction never selects state.
  assign w_unused_pc_bits = ^{i_pred_pc[1:0], i_upd_pc[1:0]};

  // Lookup path
  assign w_lkp_btb_idx = i_pred_pc[BTB_IDX_W+1:2];
  assign w_lkp_tag     = i_pred_pc[31:BTB_IDX_W+2];
  assign w_lkp_uncond  = r_btb_uncond[w_lkp_btb_idx];
  assign w_hit         = r_btb_valid[w_lkp_btb_idx] &&
                         (r_btb_tag[w_lkp_btb_idx] == w_lkp_tag);
  assign w_taken       = w_hit && (w_lkp_uncond || w_lkp_ctr[CTR_WIDTH-1]);

  // Fetch hashes with speculative history, commit with committed history.
  assign w_lkp_pht_idx = i_pred_pc[PHT_IDX_W+1:2] ^
                         ((USE_GSHARE != 0) ? PHT_IDX_W'(r_spec_ghr) : '0);
  assign w_upd_pht_idx = i_upd_pc[PHT_IDX_W+1:2] ^
                         ((USE_GSHARE != 0) ? PHT_IDX_W'(r_commit_ghr) : '0);

  assign o_pred_hit    = w_hit;
  assign o_pred_taken  = w_taken;
  assign o_pred_target = w_taken ? r_btb_target[w_lkp_btb_idx] : gsh_pc_plus4(i_pred_pc);
  assign o_pred_ghr    = r_spec_ghr;

  // Update path
  assign w_upd_btb_idx     = i_upd_pc[BTB_IDX_W+1:2];
  assign w_upd_br          = i_upd_valid && i_upd_is_br;
  assign w_commit_ghr_next = w_upd_br ? ((r_commit_ghr << 1) | GHR_WIDTH'(i_upd_taken))
                                      : r_commit_ghr;

  gsh_pht #(
    .DEPTH (PHT_DEPTH),
    .WIDTH (CTR_WIDTH)
  ) u_pht (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rd_idx  (w_lkp_pht_idx),
    .o_rd_ctr  (w_lkp_ctr),
    .i_upd_en  (w_upd_br),
    .i_upd_idx (w_upd_pht_idx),
    .i_upd_inc (i_upd_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spec_ghr   <= '0;
      r_commit_ghr <= '0;
    end else begin
      r_commit_ghr <= w_commit_ghr_next;
      // A flush restores history to the architectural point, including the
      // branch that caused it, and overrides any shift from this cycle's fetch.
      if (i_upd_valid && i_upd_miss)
        r_spec_ghr <= w_commit_ghr_next;
      else if (i_pred_req && w_hit && !w_lkp_uncond)
        r_spec_ghr <= (r_spec_ghr << 1) | GHR_WIDTH'(w_taken);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btb_valid <= '0;
    end else if (i_upd_valid && i_upd_taken) begin
      r_btb_valid[w_upd_btb_idx] <= 1'b1;
    end
  end

  // Payload is qualified by the valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    if (i_upd_valid && i_upd_taken) begin
      r_btb_tag[w_upd_btb_idx]    <= i_upd_pc[31:BTB_IDX_W+2];
      r_btb_target[w_upd_btb_idx] <= i_upd_target;
      r_btb_uncond[w_upd_btb_idx] <= !i_upd_is_br;
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb_gshare_branch_predictor
//   Two predictors share one stimulus stream: dut_a (2-bit counters) and
//   dut_b (3-bit counters), both bimodal-indexed. The driver pushes the
//   hand-derived expected lookup result into a scoreboard queue; the monitor
//   pops and compares on the falling edge of every cycle with pred_req high.
module tb_gshare_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pred_req = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_is_br = 1'b0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_miss = 1'b0;

  logic        a_hit, a_taken, b_hit, b_taken;
  logic [31:0] a_target, b_target;
  logic [5:0]  a_ghr, b_ghr;

  always #5 clk = ~clk;

  gshare_branch_predictor #(
    .PHT_DEPTH(64), .BTB_DEPTH(128), .GHR_WIDTH(6), .CTR_WIDTH(2), .USE_GSHARE(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .i_pred_req(pred_req), .i_pred_pc(pred_pc),
    .o_pred_hit(a_hit), .o_pred_taken(a_taken), .o_pred_target(a_target),
    .o_pred_ghr(a_ghr), .i_upd_valid(upd_valid), .i_upd_pc(upd_pc),
    .i_upd_is_br(upd_is_br), .i_upd_taken(upd_taken),
    .i_upd_target(upd_target), .i_upd_miss(upd_miss)
  );

  gshare_branch_predictor #(
    .PHT_DEPTH(64), .BTB_DEPTH(128), .GHR_WIDTH(6), .CTR_WIDTH(3), .USE_GSHARE(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .i_pred_req(pred_req), .i_pred_pc(pred_pc),
    .o_pred_hit(b_hit), .o_pred_taken(b_taken), .o_pred_target(b_target),
    .o_pred_ghr(b_ghr), .i_upd_valid(upd_valid), .i_upd_pc(upd_pc),
    .i_upd_is_br(upd_is_br), .i_upd_taken(upd_taken),
    .i_upd_target(upd_target), .i_upd_miss(upd_miss)
  );

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    logic [5:0]  ghr;
  } pexp_t;

  typedef struct {
    int    id;
    pexp_t a;
    pexp_t b;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  step_id  = 0;

  function automatic pexp_t mk(input logic h, input logic t, input logic [31:0] tg,
                               input logic [5:0] g);
    pexp_t e;
    e.hit = h; e.taken = t; e.tgt = tg; e.ghr = g;
    return e;
  endfunction

  task automatic chk(input int id, input string what, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL step%0d %s: got 0x%08h expected 0x%08h", id, what, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (pred_req) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got lookup with empty queue expected queued entry");
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk(e.id, "a_hit",    32'(a_hit),    32'(e.a.hit));
        chk(e.id, "a_taken",  32'(a_taken),  32'(e.a.taken));
        chk(e.id, "a_target", a_target,      e.a.tgt);
        chk(e.id, "a_ghr",    32'(a_ghr),    32'(e.a.ghr));
        chk(e.id, "b_hit",    32'(b_hit),    32'(e.b.hit));
        chk(e.id, "b_taken",  32'(b_taken),  32'(e.b.taken));
        chk(e.id, "b_target", b_target,      e.b.tgt);
        chk(e.id, "b_ghr",    32'(b_ghr),    32'(e.b.ghr));
      end
    end
  end

  // Driver tasks: entered and left at posedge + 1.
  task automatic lookup(input logic [31:0] pc, input pexp_t ea, input pexp_t eb);
    sb_t e;
    step_id++;
    e.id = step_id; e.a = ea; e.b = eb;
    sb_q.push_back(e);
    pred_req = 1'b1;
    pred_pc  = pc;
    @(posedge clk); #1;
    pred_req = 1'b0;
  endtask

  task automatic lookup_both(input logic [31:0] pc, input pexp_t e);
    lookup(pc, e, e);
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic br, input logic tk,
                         input logic [31:0] tgt, input logic miss);
    upd_valid = 1'b1; upd_pc = pc; upd_is_br = br; upd_taken = tk;
    upd_target = tgt; upd_miss = miss;
  endtask

  task automatic clr_upd();
    upd_valid = 1'b0; upd_miss = 1'b0; upd_taken = 1'b0; upd_is_br = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pc, input logic br, input logic tk,
                        input logic [31:0] tgt, input int times);
    for (int i = 0; i < times; i++) begin
      set_upd(pc, br, tk, tgt, 1'b0);
      @(posedge clk); #1;
      clr_upd();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    do_reset();

    // Reset values
    lookup_both(32'h100, mk(0, 0, 32'h104, 6'd0));

    // Branch training: A ctr 1->3, B ctr 3->5
    do_reset();
    commit(32'h100, 1, 1, 32'h80, 2);
    lookup_both(32'h100, mk(1, 1, 32'h80, 6'd0));
    commit(32'h100, 1, 0, 32'h0, 1);                 // A 2, B 4
    lookup_both(32'h100, mk(1, 1, 32'h80, 6'd1));
    commit(32'h100, 1, 0, 32'h0, 1);                 // A 1, B 3
    lookup_both(32'h100, mk(1, 0, 32'h104, 6'd3));

    // Saturation: B 3->7 (clamped) ->3, A 1->3->0
    do_reset();
    commit(32'h108, 1, 1, 32'h500, 8);
    lookup_both(32'h108, mk(1, 1, 32'h500, 6'd0));
    commit(32'h108, 1, 0, 32'h0, 4);
    lookup_both(32'h108, mk(1, 0, 32'h10C, 6'd1));

    // Jump, read-before-write, aliasing, not-taken never invalidates
    do_reset();
    commit(32'h200, 0, 1, 32'h400, 1);
    lookup_both(32'h200, mk(1, 1, 32'h400, 6'd0));
    lookup_both(32'h200, mk(1, 1, 32'h400, 6'd0));   // jump did not shift spec_ghr
    set_upd(32'h400, 0, 1, 32'h600, 0);              // aliases 0x200's entry
    lookup_both(32'h200, mk(1, 1, 32'h400, 6'd0));   // sees pre-update entry
    clr_upd();
    lookup_both(32'h200, mk(0, 0, 32'h204, 6'd0));
    commit(32'h400, 1, 0, 32'h0, 1);
    lookup_both(32'h400, mk(1, 1, 32'h600, 6'd0));

    // Speculative history and flush
    do_reset();
    commit(32'h100, 1, 1, 32'h80, 1);                // A ctr 2, B ctr 4, commit_ghr 1
    commit(32'h10C, 1, 0, 32'h0, 6);                 // commit_ghr back to 0
    lookup_both(32'h100, mk(1, 1, 32'h80, 6'd0));
    lookup_both(32'h100, mk(1, 1, 32'h80, 6'd1));
    lookup_both(32'h100, mk(1, 1, 32'h80, 6'd3));
    set_upd(32'h10C, 1, 0, 32'h0, 1);                // flush wins over fetch shift
    lookup_both(32'h100, mk(1, 1, 32'h80, 6'd7));
    clr_upd();
    lookup_both(32'h100, mk(1, 1, 32'h80, 6'd0));
    upd_miss = 1'b1;                                 // miss without valid: ignored
    lookup_both(32'h100, mk(1, 1, 32'h80, 6'd1));
    upd_miss = 1'b0;
    lookup_both(32'h100, mk(1, 1, 32'h80, 6'd3));

    // Mid-operation reset: outputs clear while rst_n is low
    rst_n = 1'b0;
    lookup_both(32'h100, mk(0, 0, 32'h104, 6'd0));
    rst_n = 1'b1;
    lookup_both(32'h100, mk(0, 0, 32'h104, 6'd0));

    repeat (2) @(posedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending entries expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
